// File: rtl/pixel_stream_unpacker_pkg.sv
// Shared field positions, word layout and state encoding for the pixel stream unpacker.
package pixel_stream_pkg;

    localparam int FLUSH_BIT     = 31;
    localparam int IMG_LAST_BIT  = 30;
    localparam int TAG_LSB       = 24;
    localparam int TAG_WIDTH     = 6;
    localparam int PAYLOAD_WIDTH = 24;

    typedef struct packed {
        logic                     flush;
        logic                     img_last;
        logic [TAG_WIDTH-1:0]     tag;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } stream_word_t;

    typedef enum logic {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } unpack_state_t;

    function automatic int words_per_row(input int width, input int vpw);
        return (width + vpw - 1) / vpw;
    endfunction

    // Lanes carrying real values in the final word of a row; the rest are padding.
    function automatic int last_word_lanes(input int width, input int vpw);
        return width - (words_per_row(width, vpw) - 1) * vpw;
    endfunction

endpackage

// File: rtl/pixel_stream_unpacker_if.sv
// Bus-side and pixel-side handshake bundle of the unpacker; slave is the unpacker, master drives it.
interface pixel_stream_unpacker_if #(
    parameter int VALUE_WIDTH = 8,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28
);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    logic [31:0]          in_data;
    logic                 in_valid;
    logic                 upstream_stall;
    logic [VALUE_WIDTH-1:0] out_value;
    logic                 out_valid;
    logic                 downstream_stall;
    logic [5:0]           out_tag;
    logic [ROW_W-1:0]     out_row;
    logic [COL_W-1:0]     out_col;
    logic                 out_row_last;
    logic                 out_img_last;
    logic                 flush_out;
    logic                 err_framing;
    logic                 err_tag;

    modport master (
        output in_data, in_valid, downstream_stall,
        input  upstream_stall, out_value, out_valid, out_tag, out_row, out_col,
               out_row_last, out_img_last, flush_out, err_framing, err_tag
    );

    modport slave (
        input  in_data, in_valid, downstream_stall,
        output upstream_stall, out_value, out_valid, out_tag, out_row, out_col,
               out_row_last, out_img_last, flush_out, err_framing, err_tag
    );

endinterface

// File: rtl/pixel_stream_unpacker_img_pos_counter.sv
// Row/column position of the value currently on the output, with wrap, last flags and sync clear.
module img_pos_counter #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int ROW_W      = $clog2(IMG_HEIGHT),
    parameter int COL_W      = $clog2(IMG_WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             row_last_o,
    output logic             img_last_o,
    output logic [ROW_W-1:0] next_row_o,
    output logic [COL_W-1:0] next_col_o
);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_d;

    always_comb begin
        col_d = col_q + COL_W'(1);
        row_d = row_q;
        if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
        end
    end

    // Clear has priority so a flush landing with the final transfer still zeroes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (advance_i) begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o      = row_q;
    assign col_o      = col_q;
    assign row_last_o = (col_q == COL_MAX);
    assign img_last_o = (col_q == COL_MAX) && (row_q == ROW_MAX);
    assign next_row_o = row_d;
    assign next_col_o = col_d;

endmodule

// File: rtl/pixel_stream_unpacker.sv
// Unpacks 32-bit bus words into one pixel value per cycle with position tracking and framing check.
// Optional tag consistency check enabled by defining PIXEL_UNPACK_TAG_CHECK_EN.
module pixel_stream_unpacker #(
    parameter int VALUES_PER_WORD = 1,
    parameter int VALUE_WIDTH     = 8,
    parameter int IMG_WIDTH       = 28,
    parameter int IMG_HEIGHT      = 28
) (
    input logic                    clock,
    input logic                    reset,
    pixel_stream_unpacker_if.slave bus
);
    import pixel_stream_pkg::*;

    localparam int PW    = VALUES_PER_WORD * VALUE_WIDTH;
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int WPR   = words_per_row(IMG_WIDTH, VALUES_PER_WORD);

    localparam logic [1:0]       FULL_LANES    = 2'(VALUES_PER_WORD);
    localparam logic [1:0]       TAIL_LANES    = 2'(last_word_lanes(IMG_WIDTH, VALUES_PER_WORD));
    localparam logic [COL_W-1:0] TAIL_WORD_COL = COL_W'((WPR - 1) * VALUES_PER_WORD);
    localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(IMG_HEIGHT - 1);

    unpack_state_t        state_q;
    logic [PW-1:0]        payload_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [1:0]           lane_q;
    logic [1:0]           nlanes_q;
    logic                 flush_out_q;
    logic                 err_framing_q;

    logic                 in_flush;
    logic                 in_img_last;
    logic [TAG_WIDTH-1:0] in_tag;
    logic [ROW_W-1:0]     row, next_row, start_row;
    logic [COL_W-1:0]     col, next_col, start_col;
    logic                 row_last, img_last;
    logic                 out_xfer, final_xfer, stall;
    logic                 accept_data, accept_flush;
    logic                 word_tail, word_final;
    logic [VALUE_WIDTH-1:0] lane_val [4];

    assign in_flush    = bus.in_data[FLUSH_BIT];
    assign in_img_last = bus.in_data[IMG_LAST_BIT];
    assign in_tag      = bus.in_data[TAG_LSB +: TAG_WIDTH];

    assign out_xfer     = (state_q == EMIT) && !bus.downstream_stall;
    assign final_xfer   = out_xfer && (lane_q == nlanes_q - 2'd1);
    assign stall        = (state_q == EMIT) && !final_xfer;
    assign accept_data  = bus.in_valid && !stall && !in_flush;
    assign accept_flush = bus.in_valid && !stall && in_flush;

    // A word accepted alongside a final-lane transfer starts one position past the current one.
    assign start_row  = final_xfer ? next_row : row;
    assign start_col  = final_xfer ? next_col : col;
    assign word_tail  = (start_col == TAIL_WORD_COL);
    assign word_final = word_tail && (start_row == LAST_ROW);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < VALUES_PER_WORD) begin : g_used
                assign lane_val[gi] = payload_q[gi*VALUE_WIDTH +: VALUE_WIDTH];
            end else begin : g_pad
                assign lane_val[gi] = '0;
            end
        end
    endgenerate

    img_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_pos (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (accept_flush),
        .advance_i  (out_xfer),
        .row_o      (row),
        .col_o      (col),
        .row_last_o (row_last),
        .img_last_o (img_last),
        .next_row_o (next_row),
        .next_col_o (next_col)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= EMPTY;
            payload_q     <= '0;
            tag_q         <= '0;
            lane_q        <= '0;
            nlanes_q      <= '0;
            flush_out_q   <= 1'b0;
            err_framing_q <= 1'b0;
        end else begin
            flush_out_q <= accept_flush;
            if (out_xfer) begin
                lane_q <= lane_q + 2'd1;
            end
            if (final_xfer) begin
                state_q <= EMPTY;
            end
            if (accept_data) begin
                state_q   <= EMIT;
                payload_q <= bus.in_data[PW-1:0];
                tag_q     <= in_tag;
                lane_q    <= '0;
                nlanes_q  <= word_tail ? TAIL_LANES : FULL_LANES;
                if (in_img_last != word_final) begin
                    err_framing_q <= 1'b1;
                end
            end
            if (accept_flush) begin
                state_q       <= EMPTY;
                err_framing_q <= 1'b0;
            end
        end
    end

`ifdef PIXEL_UNPACK_TAG_CHECK_EN
    logic [TAG_WIDTH-1:0] img_tag_q;
    logic                 err_tag_q;
    logic                 first_of_image;

    assign first_of_image = (start_row == '0) && (start_col == '0);

    // The first word of an image defines the tag every later word must carry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            img_tag_q <= '0;
            err_tag_q <= 1'b0;
        end else if (accept_flush) begin
            err_tag_q <= 1'b0;
        end else if (accept_data) begin
            if (first_of_image) begin
                img_tag_q <= in_tag;
            end else if (in_tag != img_tag_q) begin
                err_tag_q <= 1'b1;
            end
        end
    end

    assign bus.err_tag = err_tag_q;
`else
    assign bus.err_tag = 1'b0;
`endif

    assign bus.upstream_stall = stall;
    assign bus.out_valid      = (state_q == EMIT);
    assign bus.out_value      = lane_val[lane_q];
    assign bus.out_tag        = tag_q;
    assign bus.out_row        = row;
    assign bus.out_col        = col;
    assign bus.out_row_last   = row_last;
    assign bus.out_img_last   = img_last;
    assign bus.flush_out      = flush_out_q;
    assign bus.err_framing    = err_framing_q;

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// Directed bench for pixel_stream_unpacker with three values per word on a 28x28 image.
module tb_pixel_stream_unpacker;
    import pixel_stream_pkg::*;

`ifdef PIXEL_UNPACK_TAG_CHECK_EN
    localparam logic TAG_EN = 1'b1;
`else
    localparam logic TAG_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] val;
        int         row;
        int         col;
        logic [5:0] tag;
        bit         fin;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   flush_seen = 0;
    int   cycles;
    logic [31:0] wq [$];
    exp_t        eq [$];

    pixel_stream_unpacker_if #(.VALUE_WIDTH(8), .IMG_WIDTH(28), .IMG_HEIGHT(28)) bus ();

    pixel_stream_unpacker #(
        .VALUES_PER_WORD (3),
        .VALUE_WIDTH     (8),
        .IMG_WIDTH       (28),
        .IMG_HEIGHT      (28)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    // Ten words per row; lane values are (row*28+col) mod 256, padding lanes carry 0xEE.
    task automatic push_row(input int r, input logic [5:0] tag, input bit mark_last);
        stream_word_t w;
        exp_t         e;
        int           c;
        for (int j = 0; j < 10; j++) begin
            w          = '0;
            w.tag      = tag;
            w.img_last = mark_last && (j == 9);
            for (int l = 0; l < 3; l++) begin
                c = j * 3 + l;
                if (c < 28) begin
                    w.payload[l*8 +: 8] = 8'(r * 28 + c);
                    e.val = 8'(r * 28 + c);
                    e.row = r;
                    e.col = c;
                    e.tag = tag;
                    e.fin = (l == 2) || (c == 27);
                    eq.push_back(e);
                end else begin
                    w.payload[l*8 +: 8] = 8'hEE;
                end
            end
            wq.push_back(w);
        end
    endtask

    task automatic push_image(input logic [5:0] tag);
        for (int r = 0; r < 28; r++) push_row(r, tag, r == 27);
    endtask

    task automatic push_flush();
        stream_word_t w;
        w       = '0;
        w.flush = 1'b1;
        wq.push_back(w);
    endtask

    task automatic one_cycle(input bit rnd);
        exp_t h;
        bit   xfer, acc, hfin;
        @(negedge clk);
        bus.downstream_stall = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        if (wq.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = wq[0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
        end
        #1;
        if (bus.flush_out) flush_seen++;
        xfer = bus.out_valid && !bus.downstream_stall;
        hfin = (eq.size() > 0) ? eq[0].fin : 1'b0;
        chk("upstream_stall", bus.upstream_stall, bus.out_valid && !(xfer && hfin));
        if (xfer) begin
            if (eq.size() == 0) begin
                chk("unexpected_output", bus.out_valid, 0);
            end else begin
                h = eq.pop_front();
                chk("out_value", bus.out_value, h.val);
                chk("out_row", bus.out_row, h.row);
                chk("out_col", bus.out_col, h.col);
                chk("out_tag", bus.out_tag, h.tag);
                chk("out_row_last", bus.out_row_last, h.col == 27);
                chk("out_img_last", bus.out_img_last, (h.row == 27) && (h.col == 27));
            end
        end
        acc = bus.in_valid && !bus.upstream_stall;
        @(posedge clk);
        if (acc) void'(wq.pop_front());
    endtask

    task automatic run(input string name, input int max_cycles, input bit rnd, output int used);
        used = 0;
        while ((wq.size() > 0 || eq.size() > 0) && used < max_cycles) begin
            one_cycle(rnd);
            used++;
        end
        chk({name, "_drained"}, wq.size() + eq.size(), 0);
        wq.delete();
        eq.delete();
        one_cycle(1'b0);
        one_cycle(1'b0);
        chk({name, "_idle_out_valid"}, bus.out_valid, 0);
        $display("step %s: %0d cycles, %0d checks so far", name, used, n_checks);
    endtask

    initial begin
        stream_word_t w;
        rst_n                = 1'b0;
        bus.in_valid         = 1'b0;
        bus.in_data          = '0;
        bus.downstream_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_upstream_stall", bus.upstream_stall, 0);
        chk("rst_row", bus.out_row, 0);
        chk("rst_col", bus.out_col, 0);
        chk("rst_tag", bus.out_tag, 0);
        chk("rst_flush_out", bus.flush_out, 0);
        chk("rst_err_framing", bus.err_framing, 0);
        chk("rst_err_tag", bus.err_tag, 0);
        rst_n = 1'b1;
        $display("step reset: %0d checks so far", n_checks);

        flush_seen = 0;
        push_flush();
        run("flush", 20, 1'b0, cycles);
        chk("flush_pulses", flush_seen, 1);
        chk("flush_row", bus.out_row, 0);

        push_image(6'd0);
        run("image_nostall", 2000, 1'b0, cycles);
        chk("throughput_cycles", cycles, 785);
        chk("img0_err_framing", bus.err_framing, 0);
        chk("img0_err_tag", bus.err_tag, 0);
        chk("img0_end_col", bus.out_col, 0);

        push_image(6'd1);
        run("image_rndstall", 6000, 1'b1, cycles);
        chk("img1_err_framing", bus.err_framing, 0);
        chk("img1_new_tag_err_tag", bus.err_tag, 0);

        for (int r = 0; r < 5; r++) push_row(r, 6'd1, 1'b0);
        run("rows0to4", 400, 1'b1, cycles);
        chk("pre_bad_err_framing", bus.err_framing, 0);
        push_row(5, 6'd1, 1'b1);
        run("row5_badlast", 200, 1'b0, cycles);
        chk("bad_err_framing", bus.err_framing, 1);
        chk("bad_row_kept", bus.out_row, 6);
        flush_seen = 0;
        push_flush();
        run("flush_clear", 20, 1'b0, cycles);
        chk("clr_err_framing", bus.err_framing, 0);
        chk("clr_flush_pulses", flush_seen, 1);
        chk("clr_row", bus.out_row, 0);

        flush_seen = 0;
        for (int r = 0; r <= 10; r++) push_row(r, 6'd2, 1'b0);
        push_flush();
        push_row(0, 6'd2, 1'b0);
        run("midflush", 1000, 1'b0, cycles);
        chk("mid_flush_pulses", flush_seen, 1);
        chk("mid_row", bus.out_row, 1);
        chk("mid_col", bus.out_col, 0);

        push_row(1, 6'd3, 1'b0);
        run("tag_change", 200, 1'b0, cycles);
        chk("tag_change_err_tag", bus.err_tag, TAG_EN);
        push_flush();
        push_row(0, 6'd5, 1'b0);
        push_row(1, 6'd5, 1'b0);
        run("tag_flushed", 200, 1'b0, cycles);
        chk("tag_flushed_err_tag", bus.err_tag, 0);

        @(negedge clk);
        w                    = '0;
        w.tag                = 6'd9;
        w.payload            = 24'h030201;
        bus.downstream_stall = 1'b1;
        bus.in_valid         = 1'b1;
        bus.in_data          = w;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
        chk("held_out_valid", bus.out_valid, 1);
        chk("held_upstream_stall", bus.upstream_stall, 1);
        chk("held_value", bus.out_value, 8'h01);
        chk("held_tag", bus.out_tag, 6'd9);
        chk("held_row", bus.out_row, 2);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_upstream_stall", bus.upstream_stall, 0);
        chk("midrst_row", bus.out_row, 0);
        chk("midrst_tag", bus.out_tag, 0);
        rst_n                = 1'b1;
        bus.downstream_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("lost_word_out_valid", bus.out_valid, 0);
        end
        $display("step midreset: %0d checks so far", n_checks);

        flush_seen = 0;
        push_flush();
        push_row(0, 6'd7, 1'b0);
        run("after_reset", 200, 1'b1, cycles);
        chk("after_reset_flush_pulses", flush_seen, 1);
        chk("after_reset_row", bus.out_row, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
